fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the 64-bit program counter and sequences instruction-memory requests. It resolves taken branches from the EX-stage `branch`/`zero` pair into PC redirects and pipeline flushes. It presents one fetched instruction at a time to decode through a single-entry output register, with back-pressure from the hazard unit's `stall`. It sits between the instruction memory port and the IF/ID register, and computes the branch target itself as `branch_pc + 4 + (imm_ext << IMM_SHIFT)`.

---
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch controller. Owns the program counter, issues one
//   instruction-memory request at a time, and presents fetched words to
//   decode through a single-entry output register. A taken EX-stage branch
//   (branch & zero) redirects the PC to branch_pc + 4 + (imm_ext << IMM_SHIFT),
//   empties the output register and pulses flush for one cycle.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   IMM_SHIFT   left shift applied to imm_ext for the branch offset
//
// Ports
//   clk, reset              clock (rising edge), synchronous active-low reset
//   stall                   decode cannot accept; output register holds
//   branch, zero            EX-stage branch control and ALU zero flag
//   branch_pc, imm_ext      branch instruction PC and sign-extended immediate
//   imem_req, imem_addr     memory request; address stable until imem_ready
//   imem_ready, imem_rdata  same-cycle accept/return from instruction memory
//   instr_valid, instr,     output register contents
//   instr_pc
//   flush                   one-cycle squash pulse after a taken branch
//   pc                      next address to be fetched
//   taken_count             number of taken branches (wraps)
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned IMM_SHIFT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [63:0] branch_pc,
    input  logic [63:0] imm_ext,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        flush,
    output logic [63:0] pc,
    output logic [31:0] taken_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q;
    logic        req_active_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [63:0] instr_pc_q;
    logic        flush_q;
    logic [31:0] taken_count_q;

    logic        take;
    logic        redirect;
    logic        start;
    logic        load;
    logic [63:0] target;

    assign take     = branch & zero;
    assign redirect = take & (state_q != S_IDLE);
    assign target   = branch_pc + 64'd4 + (imm_ext << IMM_SHIFT);

    // A request is launched combinationally so a zero-wait memory can
    // sustain one word per cycle while the output slot drains. Once
    // launched without an immediate ready, req_active_q and addr_q pin
    // the request until imem_ready.
    assign start     = (state_q == S_FETCH) & ~req_active_q & ~take
                     & (~valid_q | ~stall);
    assign imem_req  = req_active_q | start;
    assign imem_addr = start ? pc_q : addr_q;

    // Returned data is kept only in FETCH with no redirect in the same cycle.
    assign load = (state_q == S_FETCH) & imem_req & imem_ready & ~take;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (take && req_active_q && !imem_ready) state_d = S_DISCARD;
            S_DISCARD: if (imem_ready) state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target;
        end else if (load) begin
            pc_d = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= '0;
            req_active_q  <= 1'b0;
            valid_q       <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            flush_q       <= 1'b0;
            taken_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_active_q <= imem_req & ~imem_ready;
            flush_q      <= redirect;
            if (start) begin
                addr_q <= pc_q;
            end
            if (redirect) begin
                taken_count_q <= taken_count_q + 32'd1;
            end
            // Redirect beats both a new load and a stall hold.
            if (redirect) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q    <= 1'b1;
                instr_q    <= imem_rdata;
                instr_pc_q <= imem_addr;
            end else if (!stall) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign flush       = flush_q;
    assign pc          = pc_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer (RESET_PC = 0x1000, IMM_SHIFT = 1).
//   The bench acts as instruction memory (rdata is a fixed function of the
//   address). Each scenario task pushes the instruction addresses it expects
//   decode to consume; a posedge monitor pops and compares on consumption.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [63:0] branch_pc;
    logic [63:0] imm_ext;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        flush;
    logic [63:0] pc;
    logic [31:0] taken_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    fetch_sequencer #(
        .RESET_PC (64'h1000),
        .IMM_SHIFT(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .branch     (branch),
        .zero       (zero),
        .branch_pc  (branch_pc),
        .imm_ext    (imm_ext),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .flush      (flush),
        .pc         (pc),
        .taken_count(taken_count)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: an instruction is consumed when valid, not stalled and not
    // squashed by a taken branch in the same cycle.
    always @(posedge clk) begin
        logic [63:0] exp_pc;
        if (reset && instr_valid && !stall && !(branch && zero)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: consumed instr_pc=%h, none expected", instr_pc);
            end else begin
                exp_pc = sb_q.pop_front();
                if ({instr_pc, instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    n_err++;
                    $display("FAIL sb_instr: got pc=%h instr=%h, want pc=%h instr=%h",
                             instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
            end
        end
        if (reset && flush && instr_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL flush_valid_overlap: flush=%b instr_valid=%b, want not both 1",
                     flush, instr_valid);
        end
    end

    task automatic restart();
        reset      = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        branch_pc  = '0;
        imm_ext    = '0;
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        imem_ready = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        branch     = 1'b1;
        zero       = 1'b1;
        imem_ready = 1'b1;
        stall      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc, flush, pc, taken_count} !==
            {1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h1000, 32'h0}) begin
            n_err++;
            $display("FAIL reset_values: got req=%b addr=%h v=%b instr=%h ipc=%h fl=%b pc=%h cnt=%h, want 0/0/0/0/0/0/1000/0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, flush, pc, taken_count);
        end
        reset = 1'b1;   // release; take held high during IDLE must be ignored
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: got imem_req=%b, want 0", imem_req);
        end
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        #1;
        n_cmp++;
        if ({flush, taken_count, pc, imem_req, imem_addr} !== {1'b0, 32'h0, 64'h1000, 1'b1, 64'h1000}) begin
            n_err++;
            $display("FAIL idle_take_ignored: got fl=%b cnt=%h pc=%h req=%b addr=%h, want 0/0/1000/1/1000",
                     flush, taken_count, pc, imem_req, imem_addr);
        end
        sb_q.push_back(64'h1000);
        drain();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_sb_empty: got %0d pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_stream();
        logic [63:0] a;
        restart();
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            a = 64'h1000 + 64'(4 * i);
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, a}) begin
                n_err++;
                $display("FAIL stream_addr[%0d]: got req=%b addr=%h, want 1/%h", i, imem_req, imem_addr, a);
            end
            sb_q.push_back(a);
            if (i > 0) begin
                n_cmp++;
                if ({instr_valid, instr_pc} !== {1'b1, a - 64'd4}) begin
                    n_err++;
                    $display("FAIL stream_ipc[%0d]: got v=%b ipc=%h, want 1/%h", i, instr_valid, instr_pc, a - 64'd4);
                end
            end
        end
        drain();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL stream_sb_empty: got %0d pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_stall();
        logic [63:0] a;
        restart();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            a = 64'h1000 + 64'(4 * i);
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, a}) begin
                n_err++;
                $display("FAIL stall_pre_addr[%0d]: got req=%b addr=%h, want 1/%h", i, imem_req, imem_addr, a);
            end
            sb_q.push_back(a);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            #1;
            n_cmp++;
            if ({imem_req, instr_valid, instr_pc, instr, pc} !==
                {1'b0, 1'b1, 64'h1008, mem_word(64'h1008), 64'h100C}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got req=%b v=%b ipc=%h instr=%h pc=%h, want 0/1/1008/%h/100c",
                         k, imem_req, instr_valid, instr_pc, instr, pc, mem_word(64'h1008));
            end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h100C}) begin
            n_err++;
            $display("FAIL stall_release: got req=%b addr=%h, want 1/100c", imem_req, imem_addr);
        end
        sb_q.push_back(64'h100C);
        drain();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_sb_empty: got %0d pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_branch();
        restart();
        imem_ready = 1'b1;
        branch_pc  = 64'h2000;
        imm_ext    = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        #1;
        sb_q.push_back(64'h1000);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h1004}) begin
            n_err++;
            $display("FAIL br_pre_addr: got req=%b addr=%h, want 1/1004", imem_req, imem_addr);
        end
        @(negedge clk);
        branch = 1'b1;
        zero   = 1'b1;
        #1;
        n_cmp++;
        if ({imem_req, instr_valid, instr_pc, taken_count} !== {1'b0, 1'b1, 64'h1004, 32'h0}) begin
            n_err++;
            $display("FAIL br_take_cycle: got req=%b v=%b ipc=%h cnt=%h, want 0/1/1004/0",
                     imem_req, instr_valid, instr_pc, taken_count);
        end
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        #1;
        n_cmp++;
        if ({flush, instr_valid, taken_count, pc, imem_req, imem_addr} !==
            {1'b1, 1'b0, 32'd1, 64'h1FF4, 1'b1, 64'h1FF4}) begin
            n_err++;
            $display("FAIL br_redirect: got fl=%b v=%b cnt=%h pc=%h req=%b addr=%h, want 1/0/1/1ff4/1/1ff4",
                     flush, instr_valid, taken_count, pc, imem_req, imem_addr);
        end
        sb_q.push_back(64'h1FF4);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({flush, instr_valid, instr_pc, imem_addr} !== {1'b0, 1'b1, 64'h1FF4, 64'h1FF8}) begin
            n_err++;
            $display("FAIL br_target_valid: got fl=%b v=%b ipc=%h addr=%h, want 0/1/1ff4/1ff8",
                     flush, instr_valid, instr_pc, imem_addr);
        end
        sb_q.push_back(64'h1FF8);
        drain();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL br_sb_empty: got %0d pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_not_taken();
        restart();
        imem_ready = 1'b1;
        branch_pc  = 64'h2000;
        imm_ext    = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        #1;
        sb_q.push_back(64'h1000);
        @(negedge clk);
        branch = 1'b1;
        zero   = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h1004}) begin
            n_err++;
            $display("FAIL nt_addr: got req=%b addr=%h, want 1/1004", imem_req, imem_addr);
        end
        sb_q.push_back(64'h1004);
        @(negedge clk);
        branch = 1'b0;
        #1;
        n_cmp++;
        if ({flush, taken_count, pc, imem_addr} !== {1'b0, 32'h0, 64'h1008, 64'h1008}) begin
            n_err++;
            $display("FAIL nt_sequential: got fl=%b cnt=%h pc=%h addr=%h, want 0/0/1008/1008",
                     flush, taken_count, pc, imem_addr);
        end
        sb_q.push_back(64'h1008);
        drain();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL nt_sb_empty: got %0d pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_redirect_wait();
        restart();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            sb_q.push_back(64'h1000 + 64'(4 * i));
        end
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h1010}) begin
            n_err++;
            $display("FAIL rw_wait0: got req=%b addr=%h, want 1/1010", imem_req, imem_addr);
        end
        @(negedge clk);
        branch    = 1'b1;
        zero      = 1'b1;
        branch_pc = 64'h3000;
        imm_ext   = 64'h10;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h1010}) begin
            n_err++;
            $display("FAIL rw_wait1: got req=%b addr=%h, want 1/1010", imem_req, imem_addr);
        end
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, flush, instr_valid, taken_count, pc} !==
            {1'b1, 64'h1010, 1'b1, 1'b0, 32'd1, 64'h3024}) begin
            n_err++;
            $display("FAIL rw_discard: got req=%b addr=%h fl=%b v=%b cnt=%h pc=%h, want 1/1010/1/0/1/3024",
                     imem_req, imem_addr, flush, instr_valid, taken_count, pc);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, flush} !== {1'b1, 64'h1010, 1'b0}) begin
            n_err++;
            $display("FAIL rw_ready: got req=%b addr=%h fl=%b, want 1/1010/0", imem_req, imem_addr, flush);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({instr_valid, flush, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 64'h3024}) begin
            n_err++;
            $display("FAIL rw_dropped: got v=%b fl=%b req=%b addr=%h, want 0/0/1/3024",
                     instr_valid, flush, imem_req, imem_addr);
        end
        sb_q.push_back(64'h3024);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({instr_valid, instr_pc, imem_addr} !== {1'b1, 64'h3024, 64'h3028}) begin
            n_err++;
            $display("FAIL rw_target: got v=%b ipc=%h addr=%h, want 1/3024/3028", instr_valid, instr_pc, imem_addr);
        end
        sb_q.push_back(64'h3028);
        drain();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL rw_sb_empty: got %0d pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        restart();
        imem_ready = 1'b1;
        @(negedge clk);
        #1;
        sb_q.push_back(64'h1000);
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h1004}) begin
            n_err++;
            $display("FAIL rm_pending: got req=%b addr=%h, want 1/1004", imem_req, imem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc, flush, pc, taken_count} !==
            {1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h1000, 32'h0}) begin
            n_err++;
            $display("FAIL rm_reset_values: got req=%b addr=%h v=%b instr=%h ipc=%h fl=%b pc=%h cnt=%h, want 0/0/0/0/0/0/1000/0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, flush, pc, taken_count);
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL rm_sb_empty: got %0d pending, want 0", sb_q.size());
        end
        reset = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        force dut.taken_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.taken_count_q;
        #1;
        n_cmp++;
        if (taken_count !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preload: got cnt=%h, want ffffffff", taken_count);
        end
        branch    = 1'b1;
        zero      = 1'b1;
        branch_pc = 64'h2000;
        imm_ext   = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        #1;
        n_cmp++;
        if ({taken_count, flush, pc} !== {32'h0, 1'b1, 64'h1FF4}) begin
            n_err++;
            $display("FAIL wrap_count: got cnt=%h fl=%b pc=%h, want 0/1/1ff4", taken_count, flush, pc);
        end
    endtask

    initial begin
        reset      = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        branch_pc  = '0;
        imm_ext    = '0;
        imem_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_not_taken();
        test_redirect_wait();
        test_reset_mid_and_wrap();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
